// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel between the fetch stage (master)
// and instruction memory (slave): single outstanding request, response >=1 cycle after grant.
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [31:0]     imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );
endinterface

// File: rtl/fetch_stage.sv
// RV32I IF stage plus IF/ID register: owns the PC, keeps one fetch outstanding,
// parks a response in a 1-entry buffer when decode cannot take it.
module fetch_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             stall_f_i,
    input  logic             stall_d_i,
    input  logic             flush_d_i,
    input  logic             pc_src_e_i,
    input  logic [XLEN-1:0]  pc_target_e_i,
    fetch_stage_if.master    imem,
    output logic [31:0]      instr_d_o,
    output logic [XLEN-1:0]  pc_d_o,
    output logic [XLEN-1:0]  pc_plus4_d_o,
    output logic             valid_d_o
);

    typedef enum logic [1:0] {
        IDLE,
        PEND,
        KILL
    } state_e;

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_e          state_q, state_d;
    logic            started_q;
    logic [XLEN-1:0] pc_f_q;
    logic [XLEN-1:0] pend_pc_q;

    logic            buf_valid_q;
    logic [31:0]     buf_instr_q;
    logic [XLEN-1:0] buf_pc_q;

    logic deliver;
    logic direct;
    logic req;
    logic grant;

    // A response is usable only if it belongs to the current path.
    assign deliver = (state_q == PEND) && imem.imem_rvalid_i && !pc_src_e_i;
    assign direct  = deliver && !stall_d_i && !flush_d_i && !buf_valid_q;

    // Issuing in the same cycle a direct response lands keeps zero-wait memory at 1 instr/cycle.
    assign req   = started_q && !stall_f_i && !pc_src_e_i && !buf_valid_q
                && ((state_q == IDLE) || direct);
    assign grant = req && imem.imem_gnt_i;

    assign imem.imem_req_o  = req;
    assign imem.imem_addr_o = pc_f_q;

    always_comb begin
        // NOTE: default first, so every path through this block assigns state_d and no latch is inferred.
        state_d = state_q;
        if (pc_src_e_i) begin
            if (imem.imem_rvalid_i)  state_d = IDLE;
            else if (state_q == PEND) state_d = KILL;
        end else if (grant) begin
            state_d = PEND;
        end else if (imem.imem_rvalid_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            started_q <= 1'b0;
            pc_f_q    <= RESET_PC;
            pend_pc_q <= RESET_PC;
        end else begin
            state_q   <= state_d;
            started_q <= 1'b1;
            if (pc_src_e_i) begin
                pc_f_q <= pc_target_e_i;
            end else if (grant) begin
                pc_f_q    <= pc_f_q + PC_STEP;
                pend_pc_q <= pc_f_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            buf_valid_q <= 1'b0;
        end else if (pc_src_e_i) begin
            buf_valid_q <= 1'b0;
        end else if (deliver && !direct) begin
            buf_valid_q <= 1'b1;
        end else if (buf_valid_q && !flush_d_i && !stall_d_i) begin
            buf_valid_q <= 1'b0;
        end
    end

    // NOTE: buffer payload has no reset; buf_valid_q qualifies it, so its power-up contents never escape.
    always_ff @(posedge clk_i) begin
        if (deliver && !direct) begin
            buf_instr_q <= imem.imem_rdata_i;
            buf_pc_q    <= pend_pc_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            instr_d_o    <= NOP_INSTR;
            pc_d_o       <= '0;
            pc_plus4_d_o <= '0;
            valid_d_o    <= 1'b0;
        end else if (flush_d_i) begin
            instr_d_o <= NOP_INSTR;
            valid_d_o <= 1'b0;
        end else if (stall_d_i) begin
            instr_d_o <= instr_d_o;
        end else if (buf_valid_q) begin
            instr_d_o    <= buf_instr_q;
            pc_d_o       <= buf_pc_q;
            pc_plus4_d_o <= buf_pc_q + PC_STEP;
            valid_d_o    <= 1'b1;
        end else if (direct) begin
            instr_d_o    <= imem.imem_rdata_i;
            pc_d_o       <= pend_pc_q;
            pc_plus4_d_o <= pend_pc_q + PC_STEP;
            valid_d_o    <= 1'b1;
        end else begin
            instr_d_o <= NOP_INSTR;
            valid_d_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner
// sequences, then random hazards against an in-order instruction-stream model.
module tb_fetch_stage;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        stall_f = 1'b0, stall_d = 1'b0, flush_d = 1'b0, pc_src = 1'b0;
    logic [31:0] pc_target = '0;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d;

    fetch_stage_if #(.XLEN(32)) imem ();

    fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .stall_f_i     (stall_f),
        .stall_d_i     (stall_d),
        .flush_d_i     (flush_d),
        .pc_src_e_i    (pc_src),
        .pc_target_e_i (pc_target),
        .imem          (imem),
        .instr_d_o     (instr_d),
        .pc_d_o        (pc_d),
        .pc_plus4_d_o  (pc_plus4_d),
        .valid_d_o     (valid_d)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // memory model: one outstanding request, response mem_cnt cycles after grant
    bit          mem_out  = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt  = 0;
    int          mem_lat  = 1;
    bit          mem_rand = 1'b0;

    // instruction-stream scoreboard
    bit          sb_on  = 1'b0;
    logic [31:0] exp_pc = '0;
    int          n_deliv = 0;

    logic        req_s;
    logic [31:0] addr_s;
    logic        snap_v;
    logic [31:0] snap_pc, snap_instr, snap_p4;

    typedef struct {
        logic        sd;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_instr;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(input logic sd, input logic er, input logic [31:0] ea,
                                input logic ev, input logic [31:0] ep);
        vec_t v;
        v.sd        = sd;
        v.exp_req   = er;
        v.exp_addr  = ea;
        v.exp_valid = ev;
        v.exp_pc    = ep;
        v.exp_instr = ev ? (ep ^ KEY) : NOP;
        return v;
    endfunction

    task automatic scoreboard(input logic sd, input logic fl, input logic ps, input logic [31:0] tgt);
        if (ps) begin
            exp_pc = tgt;
            check("sb_redirect_bubble", {31'b0, valid_d}, 32'd0);
        end else if (fl) begin
            check("sb_flush_bubble", {31'b0, valid_d}, 32'd0);
        end else if (sd) begin
            check("sb_stall_hold_pc", pc_d, snap_pc);
            check("sb_stall_hold_instr", instr_d, snap_instr);
            check("sb_stall_hold_valid", {31'b0, valid_d}, {31'b0, snap_v});
        end else if (valid_d) begin
            check("sb_pc", pc_d, exp_pc);
            check("sb_instr", instr_d, exp_pc ^ KEY);
            check("sb_pc_plus4", pc_plus4_d, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            n_deliv++;
        end
    endtask

    // One clock cycle: drive at negedge, sample combinational request, then check after posedge.
    task automatic step(input logic sf, input logic sd, input logic fl, input logic ps,
                        input logic [31:0] tgt, input logic g);
        logic rv;
        @(negedge clk);
        stall_f = sf; stall_d = sd; flush_d = fl; pc_src = ps; pc_target = tgt;
        imem.imem_gnt_i = g;
        rv = mem_out && (mem_cnt == 1);
        imem.imem_rvalid_i = rv;
        imem.imem_rdata_i  = rv ? (mem_addr ^ KEY) : 32'hDEAD_BEEF;
        #1;
        req_s = imem.imem_req_o;
        addr_s = imem.imem_addr_o;
        snap_v = valid_d; snap_pc = pc_d; snap_instr = instr_d; snap_p4 = pc_plus4_d;
        if (rv) mem_out = 1'b0;
        else if (mem_out) mem_cnt--;
        if (req_s && g) begin
            check("single_outstanding", {31'b0, mem_out}, 32'd0);
            mem_out  = 1'b1;
            mem_addr = addr_s;
            mem_cnt  = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        end
        @(posedge clk);
        #1;
        if (sb_on) scoreboard(sd, fl, ps, tgt);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    endtask

    task automatic wait_req(input string nm);
        int n = 0;
        do begin idle(); n++; end while (!req_s && n < 20);
        check(nm, {31'b0, req_s}, 32'd1);
    endtask

    task automatic wait_valid(input string nm);
        int n = 0;
        do begin idle(); n++; end while (!valid_d && n < 20);
        check(nm, {31'b0, valid_d}, 32'd1);
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", {31'b0, valid_d}, 32'd0);
        check("rst_instr", instr_d, NOP);
        check("rst_pc_d", pc_d, 32'd0);
        check("rst_pc_plus4", pc_plus4_d, 32'd0);
        check("rst_req", {31'b0, imem.imem_req_o}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; pc_src = 1'b0;
        imem.imem_gnt_i = 1'b0; imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = '0;
        mem_out = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [8:0]  ws_req, ws_val;
        bit          seen;
        int          n;
        logic        r_sf, r_sd, r_fl, r_ps;
        logic [31:0] r_tgt;

        imem.imem_gnt_i = 1'b0; imem.imem_rvalid_i = 1'b0; imem.imem_rdata_i = '0;

        // zero-wait back-to-back fetch, then decode stall while 0x8 arrives
        tbl[0] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0);
        tbl[1] = mk(1'b0, 1'b1, 32'h0,  1'b0, 32'h0);
        tbl[2] = mk(1'b0, 1'b1, 32'h4,  1'b1, 32'h0);
        tbl[3] = mk(1'b0, 1'b1, 32'h8,  1'b1, 32'h4);
        tbl[4] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h4);
        tbl[5] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h4);
        tbl[6] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h4);
        tbl[7] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8);
        tbl[8] = mk(1'b0, 1'b1, 32'hC,  1'b0, 32'h8);
        tbl[9] = mk(1'b0, 1'b1, 32'h10, 1'b1, 32'hC);

        mem_lat = 1;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(1'b0, tbl[i].sd, 1'b0, 1'b0, 32'h0, 1'b1);
            check($sformatf("tbl%0d_req", i), {31'b0, req_s}, {31'b0, tbl[i].exp_req});
            if (tbl[i].exp_req) check($sformatf("tbl%0d_addr", i), addr_s, tbl[i].exp_addr);
            check($sformatf("tbl%0d_valid", i), {31'b0, valid_d}, {31'b0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_pc_d", i), pc_d, tbl[i].exp_pc);
            check($sformatf("tbl%0d_instr", i), instr_d, tbl[i].exp_instr);
            if (tbl[i].exp_valid)
                check($sformatf("tbl%0d_pc_plus4", i), pc_plus4_d, tbl[i].exp_pc + 32'd4);
        end

        // three-cycle wait states: one request outstanding, bubbles in between
        mem_lat = 3;
        do_reset();
        ws_req = 9'b010010010;
        ws_val = 9'b010010000;
        for (int i = 0; i < 9; i++) begin
            idle();
            check($sformatf("ws%0d_req", i), {31'b0, req_s}, {31'b0, ws_req[i]});
            check($sformatf("ws%0d_valid", i), {31'b0, valid_d}, {31'b0, ws_val[i]});
        end
        check("ws_pc_d", pc_d, 32'h4);
        check("ws_pc_plus4", pc_plus4_d, 32'h8);

        // redirect to 0x100 while the 0x10 fetch is outstanding
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            idle();
            if (req_s && addr_s == 32'h10) seen = 1'b1;
        end
        check("redir_saw_0x10_issue", {31'b0, seen}, 32'd1);
        idle();
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h100, 1'b1);
        check("redir_req_blocked", {31'b0, req_s}, 32'd0);
        check("redir_bubble", {31'b0, valid_d}, 32'd0);
        n = 0;
        do begin
            idle();
            n++;
            if (!req_s) check("redir_no_stale_in_id", {31'b0, valid_d}, 32'd0);
        end while (!req_s && n < 20);
        check("redir_first_addr", addr_s, 32'h100);
        wait_valid("redir_target_arrives");
        check("redir_target_pc", pc_d, 32'h100);
        check("redir_target_instr", instr_d, 32'h100 ^ KEY);

        // redirect in the same cycle as a fetch stall
        step(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 1'b1);
        check("sfredir_req", {31'b0, req_s}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
            check("sfredir_stalled_req", {31'b0, req_s}, 32'd0);
        end
        wait_req("sfredir_resume");
        check("sfredir_first_addr", addr_s, 32'h200);

        // PC wrap at the top of the address space
        mem_lat = 1;
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_valid("wrap_first");
        check("wrap_pc_d", pc_d, 32'hFFFF_FFFC);
        check("wrap_pc_plus4", pc_plus4_d, 32'h0);
        check("wrap_instr", instr_d, 32'hFFFF_FFFC ^ KEY);
        wait_valid("wrap_second");
        check("wrap_next_pc_d", pc_d, 32'h0);
        check("wrap_next_pc_plus4", pc_plus4_d, 32'h4);

        // asynchronous reset in the middle of an outstanding fetch
        mem_lat = 3;
        wait_req("areset_issue");
        idle();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outputs();
        mem_cnt = 1;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        idle();
        check("areset_not_started_req", {31'b0, req_s}, 32'd0);
        idle();
        check("areset_first_req", {31'b0, req_s}, 32'd1);
        check("areset_first_addr", addr_s, 32'h0);
        wait_valid("areset_first_valid");
        check("areset_pc_d", pc_d, 32'h0);
        check("areset_instr", instr_d, 32'h0 ^ KEY);

        // random hazards against the in-order stream model
        do_reset();
        mem_rand = 1'b1;
        sb_on    = 1'b1;
        exp_pc   = 32'h0;
        n_deliv  = 0;
        for (int i = 0; i < 3000; i++) begin
            r_sf  = ($urandom_range(0, 99) < 15);
            r_sd  = ($urandom_range(0, 99) < 15);
            r_ps  = ($urandom_range(0, 99) < 4);
            r_fl  = r_ps || ($urandom_range(0, 99) < 5);
            r_tgt = $urandom_range(0, 32'hFFF) << 2;
            step(r_sf, r_sd, r_fl, r_ps, r_tgt, $urandom_range(0, 99) < 75);
        end
        for (int i = 0; i < 20; i++) idle();
        check("random_progress", {31'b0, n_deliv > 300}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
IF stage plus IF/ID pipeline register for the 5-stage RV32I core. Consumes stall_f/stall_d/flush_d/pc_src_e from the hazard unit (pipeline_control). Owns the PC and a single-outstanding handshake to instruction memory. Presents the decode-stage instruction, PC and PC+4, and absorbs memory wait states with a 1-entry hold buffer.

Parameters:
XLEN, 32, address/data width
RESET_PC, 32'h0000_0000, PC loaded on reset
NOP_INSTR, 32'h0000_0013, instruction driven on bubbles (addi x0,x0,0)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, asynchronous assert, active-low
stall_f_i  in  1  hazard unit: hold PC, issue no request
stall_d_i  in  1  hazard unit: hold IF/ID
flush_d_i  in  1  hazard unit: bubble IF/ID
pc_src_e_i  in  1  taken branch/jump resolved in EX
pc_target_e_i  in  XLEN  redirect target
imem_req_o  out  1  fetch request valid
imem_addr_o  out  XLEN  fetch address (= pc_f)
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid (≥1 cycle after grant)
imem_rdata_i  in  32  response instruction
instr_d_o  out  32  IF/ID instruction
pc_d_o  out  XLEN  IF/ID PC
pc_plus4_d_o  out  XLEN  IF/ID PC+4
valid_d_o  out  1  IF/ID holds a real instruction

Behaviour:
- Reset (async, rst_n_i=0): pc_f=RESET_PC, state=IDLE, buffer empty, started=0; instr_d_o=NOP_INSTR, pc_d_o=0, pc_plus4_d_o=0, valid_d_o=0. imem_req_o=0 while started=0. started sets on the first clock after deassertion. Reset mid-transaction drops the outstanding response, with no recovery.
- FSM: IDLE (nothing outstanding), PEND (outstanding, response wanted), KILL (outstanding, response to discard).
- deliver = state==PEND & imem_rvalid_i & !pc_src_e_i.
- direct = deliver & !stall_d_i & !flush_d_i & !buf_valid.
- imem_req_o = started & !stall_f_i & !pc_src_e_i & !buf_valid & (state==IDLE | direct). The combinational path from rvalid to req is permitted; this gives back-to-back fetch at 1 instr/cycle with zero-wait memory.
- Grant (req & gnt): pend_pc<=pc_f; pc_f<=pc_f+4; next state PEND.
- PEND with rvalid and no new grant -> IDLE. KILL with rvalid: response dropped -> IDLE (no issue that cycle).
- Redirect (pc_src_e_i=1) has highest priority and overrides stall_f_i:
  - pc_f<=pc_target_e_i; buffer cleared; no request.
  - PEND without rvalid -> KILL. PEND or KILL with rvalid -> response dropped, IDLE.
- Hold buffer: a delivered response that is not direct is written to the buffer with {instr, pend_pc}. Requests are blocked while the buffer is full. At most one instruction is ever buffered.
- IF/ID update priority:
  1. flush_d_i: valid=0, instr=NOP_INSTR, pc fields held.
  2. stall_d_i: hold.
  3. buf_valid: load buffer, clear buffer.
  4. direct: load {imem_rdata_i, pend_pc, pend_pc+4}, valid=1.
  5. Otherwise bubble: valid=0, instr=NOP_INSTR.
- PC arithmetic is modulo 2^XLEN; 32'hFFFF_FFFC+4 wraps to 0. Low two address bits are not checked.
- stall_f_i never blocks capture of an outstanding response.

Test Plan:
- Reset, zero-wait memory (gnt=1, rvalid 1 cycle later, rdata=addr^32'hA5A5_0000): addr 0,4,8 issued back-to-back. From cycle 2 after reset, IF/ID shows pc_d 0,4,8 with valid_d=1 each cycle; before that, instr_d=0x13 and valid_d=0.
- Wait states (rvalid 3 cycles after grant): one request outstanding, imem_req_o=0 until response. IF/ID bubbles (valid_d=0) between instructions; pc_plus4_d = pc_d+4.
- stall_d_i high for 3 cycles while response to pc 0x8 arrives: IF/ID holds pc 0x4, 0x8 goes to buffer, imem_req_o=0. On release, IF/ID loads 0x8 next cycle, then fetch resumes at 0xC.
- Redirect to 0x100 with pc_src_e_i+flush_d_i while the 0x10 response is outstanding: 0x10 is discarded on arrival (never reaches IF/ID). Next request addr=0x100; IF/ID bubble that cycle.
- stall_f_i=1 and pc_src_e_i=1 same cycle (target 0x200): pc_f=0x200. After stall_f drops, first imem_addr_o=0x200.
- Async reset asserted mid-PEND: outputs immediately return to reset values. After release, first request addr=RESET_PC and any stale rvalid is ignored.
